// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - aligned/byte-serial load/store front end for the 64-bit data memory
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned requests into errors instead of splitting them.
module lsu_align #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, BYTE = 2'd2, RESP = 2'd3} state_t;
`endif

  localparam logic [64:0] MEM_LIM = 65'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        wr_q, sgn_q;
  logic [63:0] addr_q, wdata_q;
  logic [3:0]  size_q;
  logic [63:0] resp_rdata_q;
  logic        resp_error_q;
  logic [63:0] load_val;
`ifndef LSU_MISALIGN_TRAP_EN
  logic [2:0]  k_q;
  logic [63:0] data_q, asm_next;
`endif

  logic size_ok, in_bounds, aligned, req_err, accept;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [3:0] sz, input logic sg);
    case (sz)
      4'd1:    return {{56{sg & d[7]}},  d[7:0]};
      4'd2:    return {{48{sg & d[15]}}, d[15:0]};
      4'd4:    return {{32{sg & d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Bounds are evaluated in 65 bits so addresses near 2^64 cannot wrap into range.
  assign size_ok   = (req_size == 4'd1) || (req_size == 4'd2) || (req_size == 4'd4) || (req_size == 4'd8);
  assign in_bounds = (req_addr < MEM_LIM[63:0]) &&
                     (({1'b0, req_addr} + {61'b0, req_size}) <= MEM_LIM);
  assign aligned   = (req_addr & (64'(req_size) - 64'd1)) == 64'd0;
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err   = !size_ok || !in_bounds || !aligned;
`else
  assign req_err   = !size_ok || !in_bounds;
`endif

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

  always_comb begin
    state_d          = state_q;
    mem_address      = 64'd0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = 64'd0;
    mem_xfer_size    = 4'd8;
    load_val         = 64'd0;
`ifndef LSU_MISALIGN_TRAP_EN
    asm_next         = data_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)      state_d = RESP;
          else if (aligned) state_d = XFER;
`ifndef LSU_MISALIGN_TRAP_EN
          else              state_d = BYTE;
`endif
        end
      end
      XFER: begin
        mem_address      = addr_q;
        mem_xfer_size    = size_q;
        mem_write_enable = wr_q;
        mem_read_enable  = !wr_q;
        mem_write_data   = wdata_q;
        load_val         = mem_read_data;
        state_d          = RESP;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      BYTE: begin
        mem_address      = addr_q + 64'(k_q);
        mem_xfer_size    = 4'd1;
        mem_write_enable = wr_q;
        mem_read_enable  = !wr_q;
        mem_write_data   = {56'd0, wdata_q[{k_q, 3'b000} +: 8]};
        asm_next[{k_q, 3'b000} +: 8] = mem_read_data[7:0];
        load_val         = asm_next;
        if ({1'b0, k_q} == size_q - 4'd1) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      sgn_q        <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      size_q       <= 4'd0;
      resp_rdata_q <= 64'd0;
      resp_error_q <= 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
      k_q          <= 3'd0;
      data_q       <= 64'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q         <= req_write;
        sgn_q        <= req_signed;
        addr_q       <= req_addr;
        wdata_q      <= req_wdata;
        size_q       <= req_size;
        resp_error_q <= req_err;
        resp_rdata_q <= 64'd0;
      end else if (state_q == RESP) begin
        resp_error_q <= 1'b0;
        resp_rdata_q <= 64'd0;
      end else if (state_q != IDLE && state_d == RESP) begin
        resp_rdata_q <= wr_q ? 64'd0 : extend(load_val, size_q, sgn_q);
      end
`ifndef LSU_MISALIGN_TRAP_EN
      if (accept) k_q <= 3'd0;
      else if (state_q == BYTE) begin
        k_q    <= k_q + 3'd1;
        data_q <= asm_next;
      end
`endif
    end
  end

endmodule
